// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART message scheduler: FSM states, framing
// characters and the helper that picks the byte for a given frame position.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } sched_state_t;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam int         MSG_BYTES = 6;
    localparam logic [2:0] LAST_IDX  = 3'(MSG_BYTES - 1);

    // Frame layout: four data bytes MSB first, then CR, then LF.
    function automatic logic [7:0] msg_byte(input logic [31:0] msg, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = msg[31:24];
            3'd1:    b = msg[23:16];
            3'd2:    b = msg[15:8];
            3'd3:    b = msg[7:0];
            3'd4:    b = CHAR_CR;
            default: b = CHAR_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// after ptr, wrapping around. Shared with the planned RX dispatcher.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [GNT_W-1:0]   gnt_idx
);

    logic found;
    int   pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[pos]) begin
                found        = 1'b1;
                gnt[pos]     = 1'b1;
                gnt_idx      = GNT_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_msg_scheduler.sv
// Shares one byte-wide UART TX among NUM_REQ requesters, sending each 32-bit
// word as four bytes MSB first followed by CR LF, in round-robin order.
module uart_msg_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    ack,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [GNT_W-1:0]      grant_id
);

    sched_state_t       state;
    logic [31:0]        msg_q;
    logic [2:0]         byte_idx;
    logic [GNT_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [GNT_W-1:0]   arb_idx;
    logic [31:0]        win_word;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign win_word = req_data[32*arb_idx +: 32];

    // tx_data is preloaded with the next byte on each handshake so it stays
    // stable while the serializer stalls and tx_valid never gaps mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            msg_q    <= '0;
            byte_idx <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
            ack      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (|arb_gnt) begin
                        msg_q    <= win_word;
                        grant_id <= arb_idx;
                        byte_idx <= '0;
                        tx_data  <= msg_byte(win_word, 3'd0);
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            ack      <= NUM_REQ'(1) << grant_id;
                            state    <= DONE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_data  <= msg_byte(msg_q, byte_idx + 3'd1);
                        end
                    end
                end
                DONE: begin
                    ack    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (grant_id == GNT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Self-checking bench for uart_msg_scheduler: directed scenarios plus random
// traffic compared against a frame-queue reference model.
module tb_uart_msg_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    ack;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic [1:0]      grant_id;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] m_q[$];
    int         m_owner;
    int         m_ptr;
    bit         m_ackcyc;

    logic [7:0] captured[$];
    int         ack_order[$];
    bit         drop_on_ack;

    always #5 clk = ~clk;

    uart_msg_scheduler #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .grant_id (grant_id)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_owner  = 0;
        m_ptr    = 0;
        m_ackcyc = 1'b0;
    endtask

    // One clock of the reference: a granted word becomes a 6-byte frame queue
    // that drains on ready, followed by one ack cycle.
    task automatic modelStep(input logic [N-1:0] r, input logic [32*N-1:0] d, input logic rdy);
        logic [31:0] w;
        if (m_ackcyc) begin
            m_ackcyc = 1'b0;
            m_ptr    = (m_owner + 1) % N;
        end else if (m_q.size() > 0) begin
            if (rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_ackcyc = 1'b1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (r[j]) begin
                    m_owner = j;
                    w = d[32*j +: 32];
                    m_q.push_back(w[31:24]);
                    m_q.push_back(w[23:16]);
                    m_q.push_back(w[15:8]);
                    m_q.push_back(w[7:0]);
                    m_q.push_back(8'h0D);
                    m_q.push_back(8'h0A);
                    break;
                end
            end
        end
    endtask

    task automatic checkModel();
        logic [31:0] exp_ack;
        exp_ack = m_ackcyc ? (32'd1 << m_owner) : 32'd0;
        checkOutput("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) checkOutput("tx_data", 32'(tx_data), 32'(m_q[0]));
        checkOutput("ack", 32'(ack), exp_ack);
        checkOutput("busy", 32'(busy), 32'((m_q.size() > 0) || m_ackcyc));
        checkOutput("grant_id", 32'(grant_id), 32'(m_owner));
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic rdy);
        req      = r;
        tx_ready = rdy;
    endtask

    task automatic runCycle();
        logic [N-1:0]    rs;
        logic [32*N-1:0] ds;
        logic            rdy;
        rs  = req;
        ds  = req_data;
        rdy = tx_ready;
        if (tx_valid && tx_ready) captured.push_back(tx_data);
        @(posedge clk);
        if (rst_n) modelStep(rs, ds, rdy);
        #1;
        checkModel();
        for (int i = 0; i < N; i++) if (ack[i]) ack_order.push_back(i);
        if (drop_on_ack) req = req & ~ack;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus('0, 1'b0);
        #1;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        captured.delete();
        ack_order.delete();
    endtask

    task automatic checkFrame(input string tag, input logic [31:0] w);
        logic [7:0] exp[6];
        exp = '{w[31:24], w[23:16], w[15:8], w[7:0], 8'h0D, 8'h0A};
        checkOutput({tag, "_len"}, 32'(captured.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < captured.size()) checkOutput({tag, "_byte"}, 32'(captured[k]), 32'(exp[k]));
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = '0;
        req_data    = '0;
        tx_ready    = 1'b0;
        drop_on_ack = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        rst_n = 1'b1;

        // Single requester, ready tied high.
        captured.delete();
        ack_order.delete();
        req_data[31:0] = 32'h41424344;
        applyStimulus(4'b0001, 1'b1);
        repeat (10) runCycle();
        checkFrame("single", 32'h41424344);
        checkOutput("single_acks", 32'(ack_order.size()), 32'd1);
        if (ack_order.size() > 0) checkOutput("single_ack_id", 32'(ack_order[0]), 32'd0);

        // Fairness with every requester held high.
        doReset();
        drop_on_ack = 1'b0;
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'h30303030 + 32'(i);
        applyStimulus(4'b1111, 1'b1);
        repeat (42) runCycle();
        checkOutput("fair_count", 32'(ack_order.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++)
            if (k < ack_order.size()) checkOutput("fair_order", 32'(ack_order[k]), 32'(k % N));
        drop_on_ack = 1'b1;

        // Data change and request drop after grant.
        doReset();
        req_data[31:0] = 32'hDEADBEEF;
        applyStimulus(4'b0001, 1'b1);
        runCycle();
        req_data[31:0] = 32'h12345678;
        applyStimulus(4'b0000, 1'b1);
        repeat (9) runCycle();
        checkFrame("drop", 32'hDEADBEEF);
        checkOutput("drop_acks", 32'(ack_order.size()), 32'd1);

        // Reset in the middle of a frame.
        doReset();
        req_data[31:0] = 32'h11223344;
        applyStimulus(4'b0001, 1'b1);
        repeat (3) runCycle();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("midrst_ack", 32'(ack), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_grant_id", 32'(grant_id), 32'd0);
        captured.delete();
        ack_order.delete();
        req_data[95:64] = 32'h55667788;
        applyStimulus(4'b0101, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) runCycle();
        checkOutput("midrst_acks", 32'(ack_order.size()), 32'd2);
        if (ack_order.size() > 0) checkOutput("midrst_first", 32'(ack_order[0]), 32'd0);
        if (ack_order.size() > 1) checkOutput("midrst_second", 32'(ack_order[1]), 32'd2);

        // Data bytes equal to CR.
        doReset();
        req_data[31:0] = 32'h0D0D0D0D;
        applyStimulus(4'b0001, 1'b1);
        repeat (10) runCycle();
        checkFrame("cr", 32'h0D0D0D0D);
        checkOutput("cr_idle", 32'(busy), 32'd0);

        // Random traffic with backpressure.
        doReset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 4 == 0)) begin
                    req[i] = 1'b1;
                    req_data[32*i +: 32] = $urandom;
                end else if ($urandom % 16 == 0) begin
                    req_data[32*i +: 32] = $urandom;
                end
                if (req[i] && ($urandom % 32 == 0)) req[i] = 1'b0;
            end
            tx_ready = 1'($urandom % 2);
            runCycle();
        end
        checkOutput("rand_progress", 32'(ack_order.size() > 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
